bullet_pool: RTL and testbench
==============================

// Module: bullet_pool
// PURPOSE
//  Parametrised pool of NUM_SLOTS bullets with per-slot position, size, colour and vertical speed.
//  Bullets are created through a valid/ready spawn port, advanced on a movement tick,
//  retired at the arena edge or on collision, and read through two independent ports.
//  Port A feeds the VGA renderer; port B feeds the collision checker and damage calculator.
// PARAMETERS
//  NUM_SLOTS  8    bullet slots; power of two, 2..32
//  COORD_W    8    width of x and y coordinates
//  SIZE_W     8    width of w and h sizes
//  COLOR_W    3    width of the colour code (0 white, 1 green, 2 blue)
//  SPEED_W    4    width of unsigned vertical speed, in pixels per tick
//  ARENA_MAX  200  largest legal y coordinate
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  tick         in   1        advance every active bullet by one step (one-cycle pulse)
//  spawn_valid  in   1        spawn request
//  spawn_ready  out  1        a free slot exists
//  spawn_x/y    in   COORD_W  start position
//  spawn_w/h    in   SIZE_W   bullet size
//  spawn_color  in   COLOR_W  colour code
//  spawn_vy     in   SPEED_W  vertical speed
//  rd_idx_a     in   IDX_W    renderer slot select; IDX_W = $clog2(NUM_SLOTS)
//  a_x,a_y,a_w,a_h,a_color,a_active  out  field widths  slot rd_idx_a contents
//  rd_idx_b     in   IDX_W    collision slot select
//  b_x,b_y,b_w,b_h,b_color,b_active  out  field widths  slot rd_idx_b contents
//  hit          in   1        collision on slot rd_idx_b; retire that slot
//  active_count out  IDX_W+1  number of active slots (registered)
// BEHAVIOUR
//  - Reset: every slot is inactive and all fields are 0. active_count=0, spawn_ready=1.
//  - Read ports are combinational from slot registers and have 0-cycle latency.
//  - Reads of inactive slots return the stored fields with *_active=0.
//  - spawn_ready = OR of ~active over the registered state.
//    A slot freed in cycle N is spawnable from cycle N+1.
//  - Spawn fires when valid&&ready. The lowest-index free slot is loaded at the clock edge
//    with the spawn fields and active=1. A spawned bullet does not move on the cycle it is loaded, even if tick=1.
//  - tick: for each active slot, next_y = y + vy, computed at COORD_W+1 bits.
//    If next_y > ARENA_MAX, the slot is handled as an edge crossing (see CONFIGURATION).
//    Otherwise y <= next_y. x, w, h and colour never change after spawn.
//  - hit: if slot rd_idx_b is active, it becomes inactive at the next edge.
//    A hit on an inactive slot has no effect. hit overrides tick for that slot,
//    so the retired bullet keeps its last y.
//  - Simultaneous spawn, tick and hit act on their own slots independently in one cycle.
//    Spawn never targets an active slot, so spawn and hit cannot address the same slot.
//  - active_count is updated every cycle from the next-state active vector.
//    It saturates naturally at NUM_SLOTS.
//  - Asserting rst_n low mid-operation clears all state immediately. Pending requests are dropped.
// CONFIGURATION
//  BULLET_WRAP_EN defined: an edge crossing sets y <= 1 and the slot stays active (endless stream).
//  Not defined: an edge crossing retires the slot (active <= 0) and y keeps its pre-tick value.
// STRUCTURE
//  bullet_pkg:
//   - colour constants COLOR_WHITE=0, COLOR_GREEN=1, COLOR_BLUE=2
//   - packed struct bullet_slot_t {active, color, w, h, x, y, vy}
//   - default ARENA_MAX
//  Sub-module bullet_slot_alloc: lowest-index-free priority encoder over ~active.
//   Outputs free_idx and any_free.
//  Slot storage is a flop array of bullet_slot_t, not inferred RAM (needs two async reads plus bulk update).
// TESTING
//  1. Reset, spawn x=36,y=19,vy=5 -> slot0 active, b_y=19, spawn_ready=1, active_count=1.
//  2. Slot0 at y=195, vy=5, tick -> y=200; tick again -> retired (wrap off) / y=1 active (BULLET_WRAP_EN).
//  3. Fill 8 slots -> spawn_ready=0, 9th valid held. hit on slot3 -> next cycle ready=1, spawn lands in slot3.
//  4. Same cycle: spawn (slot2 free), tick, hit on slot0 -> slot2 loaded unmoved, slot0 retired, others +vy.
//  5. hit on inactive slot5 -> no state change, active_count unchanged.
//  6. rst_n low during tick with 4 active -> all inactive at once, active_count=0, a_y=b_y=0.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet pool: field widths, colour codes,
// the per-slot record and the default arena limit.
package bullet_pkg;

   localparam int unsigned COORD_W       = 8;
   localparam int unsigned SIZE_W        = 8;
   localparam int unsigned COLOR_W       = 3;
   localparam int unsigned SPEED_W       = 4;
   localparam int unsigned ARENA_MAX_DEF = 200;

   localparam logic [COLOR_W-1:0] COLOR_WHITE = COLOR_W'(0);
   localparam logic [COLOR_W-1:0] COLOR_GREEN = COLOR_W'(1);
   localparam logic [COLOR_W-1:0] COLOR_BLUE  = COLOR_W'(2);

   typedef struct packed {
      logic               active;
      logic [COLOR_W-1:0] color;
      logic [SIZE_W-1:0]  w;
      logic [SIZE_W-1:0]  h;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [SPEED_W-1:0] vy;
   } bullet_slot_t;

endpackage

// File: rtl/bullet_slot_alloc.sv
// Lowest-index free slot finder: priority encoder over the inverted active vector.
module bullet_slot_alloc #(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] active,
   output logic [IDX_W-1:0]     free_idx,
   output logic                 any_free
);

   // Scan from the top down so the lowest free index wins last.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            free_idx = IDX_W'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bullet_pool.sv
// Pool of bullet slots: valid/ready spawn, tick-driven vertical motion,
// retirement on hit or arena edge, two combinational read ports.
// Optional macro BULLET_WRAP_EN: edge crossing wraps y to 1 instead of retiring.
module bullet_pool
   import bullet_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned ARENA_MAX = ARENA_MAX_DEF,
   localparam int unsigned IDX_W    = $clog2(NUM_SLOTS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               spawn_valid,
   output logic               spawn_ready,
   input  logic [COORD_W-1:0] spawn_x,
   input  logic [COORD_W-1:0] spawn_y,
   input  logic [SIZE_W-1:0]  spawn_w,
   input  logic [SIZE_W-1:0]  spawn_h,
   input  logic [COLOR_W-1:0] spawn_color,
   input  logic [SPEED_W-1:0] spawn_vy,
   input  logic [IDX_W-1:0]   rd_idx_a,
   output logic [COORD_W-1:0] a_x,
   output logic [COORD_W-1:0] a_y,
   output logic [SIZE_W-1:0]  a_w,
   output logic [SIZE_W-1:0]  a_h,
   output logic [COLOR_W-1:0] a_color,
   output logic               a_active,
   input  logic [IDX_W-1:0]   rd_idx_b,
   output logic [COORD_W-1:0] b_x,
   output logic [COORD_W-1:0] b_y,
   output logic [SIZE_W-1:0]  b_w,
   output logic [SIZE_W-1:0]  b_h,
   output logic [COLOR_W-1:0] b_color,
   output logic               b_active,
   input  logic               hit,
   output logic [IDX_W:0]     active_count
);

   bullet_slot_t             slot_q   [NUM_SLOTS];
   bullet_slot_t             slot_nxt [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]     active_vec;
   logic [IDX_W-1:0]         free_idx;
   logic                     any_free;
   logic [IDX_W:0]           count_nxt;
   logic [COORD_W:0]         next_y;

   // Gather the registered active flags for the allocator.
   always_comb begin
      active_vec = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         active_vec[i] = slot_q[i].active;
      end
   end

   bullet_slot_alloc #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_alloc (
      .active   (active_vec),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   assign spawn_ready = any_free;

   // Next-state slot array: hit beats tick, spawn only lands on a free slot.
   always_comb begin
      next_y    = '0;
      count_nxt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_nxt[i] = slot_q[i];
         next_y      = (COORD_W+1)'(slot_q[i].y) + (COORD_W+1)'(slot_q[i].vy);
         if (slot_q[i].active) begin
            if (hit && (rd_idx_b == IDX_W'(i))) begin
               slot_nxt[i].active = 1'b0;
            end else if (tick) begin
               if (next_y > (COORD_W+1)'(ARENA_MAX)) begin
`ifdef BULLET_WRAP_EN
                  slot_nxt[i].y = COORD_W'(1);
`else
                  slot_nxt[i].active = 1'b0;
`endif
               end else begin
                  slot_nxt[i].y = next_y[COORD_W-1:0];
               end
            end
         end
      end
      if (spawn_valid && any_free) begin
         slot_nxt[free_idx].active = 1'b1;
         slot_nxt[free_idx].color  = spawn_color;
         slot_nxt[free_idx].w      = spawn_w;
         slot_nxt[free_idx].h      = spawn_h;
         slot_nxt[free_idx].x      = spawn_x;
         slot_nxt[free_idx].y      = spawn_y;
         slot_nxt[free_idx].vy     = spawn_vy;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         count_nxt = count_nxt + (IDX_W+1)'(slot_nxt[i].active);
      end
   end

   // Slot storage and registered population count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i]       <= '0;
            slot_q[i].color <= COLOR_WHITE;
         end
         active_count <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i] <= slot_nxt[i];
         end
         active_count <= count_nxt;
      end
   end

   // Renderer read port.
   always_comb begin
      a_x      = slot_q[rd_idx_a].x;
      a_y      = slot_q[rd_idx_a].y;
      a_w      = slot_q[rd_idx_a].w;
      a_h      = slot_q[rd_idx_a].h;
      a_color  = slot_q[rd_idx_a].color;
      a_active = slot_q[rd_idx_a].active;
   end

   // Collision read port.
   always_comb begin
      b_x      = slot_q[rd_idx_b].x;
      b_y      = slot_q[rd_idx_b].y;
      b_w      = slot_q[rd_idx_b].w;
      b_h      = slot_q[rd_idx_b].h;
      b_color  = slot_q[rd_idx_b].color;
      b_active = slot_q[rd_idx_b].active;
   end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: spawn, motion, edge handling, full pool,
// simultaneous spawn/tick/hit, hit on idle slot and asynchronous reset.
module tb_bullet_pool;
   import bullet_pkg::*;

   logic               clk;
   logic               rst_n;
   logic               tick;
   logic               spawn_valid;
   logic               spawn_ready;
   logic [COORD_W-1:0] spawn_x, spawn_y;
   logic [SIZE_W-1:0]  spawn_w, spawn_h;
   logic [COLOR_W-1:0] spawn_color;
   logic [SPEED_W-1:0] spawn_vy;
   logic [2:0]         rd_idx_a, rd_idx_b;
   logic [COORD_W-1:0] a_x, a_y, b_x, b_y;
   logic [SIZE_W-1:0]  a_w, a_h, b_w, b_h;
   logic [COLOR_W-1:0] a_color, b_color;
   logic               a_active, b_active;
   logic               hit;
   logic [3:0]         active_count;

   int errors = 0;
   int checks = 0;

   bullet_pool dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .spawn_valid  (spawn_valid),
      .spawn_ready  (spawn_ready),
      .spawn_x      (spawn_x),
      .spawn_y      (spawn_y),
      .spawn_w      (spawn_w),
      .spawn_h      (spawn_h),
      .spawn_color  (spawn_color),
      .spawn_vy     (spawn_vy),
      .rd_idx_a     (rd_idx_a),
      .a_x          (a_x),
      .a_y          (a_y),
      .a_w          (a_w),
      .a_h          (a_h),
      .a_color      (a_color),
      .a_active     (a_active),
      .rd_idx_b     (rd_idx_b),
      .b_x          (b_x),
      .b_y          (b_y),
      .b_w          (b_w),
      .b_h          (b_h),
      .b_color      (b_color),
      .b_active     (b_active),
      .hit          (hit),
      .active_count (active_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge, then settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      tick        = 1'b0;
      hit         = 1'b0;
      spawn_valid = 1'b0;
      spawn_x     = '0;
      spawn_y     = '0;
      spawn_w     = '0;
      spawn_h     = '0;
      spawn_color = '0;
      spawn_vy    = '0;
      rd_idx_a    = '0;
      rd_idx_b    = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
   endtask

   task automatic set_spawn(input int x, input int y, input int vy);
      spawn_valid = 1'b1;
      spawn_x     = COORD_W'(x);
      spawn_y     = COORD_W'(y);
      spawn_w     = SIZE_W'(2);
      spawn_h     = SIZE_W'(4);
      spawn_color = COLOR_GREEN;
      spawn_vy    = SPEED_W'(vy);
   endtask

   initial begin
      // 1: reset state, then a single spawn
      do_reset();
      check("rst_count", 32'(active_count), 0);
      check("rst_ready", 32'(spawn_ready), 1);
      check("rst_b_active", 32'(b_active), 0);
      check("rst_a_y", 32'(a_y), 0);
      set_spawn(36, 19, 5);
      step();
      spawn_valid = 1'b0;
      rd_idx_b = 3'd0;
      rd_idx_a = 3'd0;
      #1;
      check("t1_b_y", 32'(b_y), 19);
      check("t1_b_x", 32'(b_x), 36);
      check("t1_b_active", 32'(b_active), 1);
      check("t1_a_color", 32'(a_color), 1);
      check("t1_ready", 32'(spawn_ready), 1);
      check("t1_count", 32'(active_count), 1);

      // 2: arena edge handling
      do_reset();
      set_spawn(10, 195, 5);
      tick = 1'b1;
      step();
      spawn_valid = 1'b0;
      check("t2_spawn_unmoved", 32'(b_y), 195);
      step();
      tick = 1'b0;
      check("t2_y_at_max", 32'(b_y), 200);
      check("t2_active_at_max", 32'(b_active), 1);
      tick = 1'b1;
      step();
      tick = 1'b0;
`ifdef BULLET_WRAP_EN
      check("t2_wrap_y", 32'(b_y), 1);
      check("t2_wrap_active", 32'(b_active), 1);
      check("t2_wrap_count", 32'(active_count), 1);
`else
      check("t2_retire_y", 32'(b_y), 200);
      check("t2_retire_active", 32'(b_active), 0);
      check("t2_retire_count", 32'(active_count), 0);
`endif

      // 3: fill the pool, stall, free slot 3, refill it
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_spawn(i, 10 * i, 1);
         step();
      end
      check("t3_full_ready", 32'(spawn_ready), 0);
      check("t3_full_count", 32'(active_count), 8);
      set_spawn(0, 99, 1);
      step();
      step();
      rd_idx_b = 3'd3;
      #1;
      check("t3_held_y", 32'(b_y), 30);
      check("t3_held_count", 32'(active_count), 8);
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("t3_hit_ready", 32'(spawn_ready), 1);
      check("t3_hit_count", 32'(active_count), 7);
      check("t3_hit_active", 32'(b_active), 0);
      step();
      spawn_valid = 1'b0;
      check("t3_refill_y", 32'(b_y), 99);
      check("t3_refill_active", 32'(b_active), 1);
      check("t3_refill_count", 32'(active_count), 8);
      check("t3_refill_ready", 32'(spawn_ready), 0);

      // 4: spawn into slot 2, tick and hit slot 0 in the same cycle
      rd_idx_b = 3'd2;
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("t4_pre_count", 32'(active_count), 7);
      set_spawn(77, 50, 3);
      tick = 1'b1;
      hit = 1'b1;
      rd_idx_b = 3'd0;
      step();
      spawn_valid = 1'b0;
      tick = 1'b0;
      hit = 1'b0;
      #1;
      check("t4_s0_active", 32'(b_active), 0);
      check("t4_s0_y", 32'(b_y), 0);
      rd_idx_a = 3'd2;
      #1;
      check("t4_s2_y", 32'(a_y), 50);
      check("t4_s2_x", 32'(a_x), 77);
      check("t4_s2_active", 32'(a_active), 1);
      rd_idx_a = 3'd1;
      #1;
      check("t4_s1_y", 32'(a_y), 11);
      rd_idx_a = 3'd3;
      #1;
      check("t4_s3_y", 32'(a_y), 100);
      rd_idx_a = 3'd7;
      #1;
      check("t4_s7_y", 32'(a_y), 71);
      check("t4_count", 32'(active_count), 7);

      // 5: hit on an idle slot changes nothing
      rd_idx_b = 3'd5;
      hit = 1'b1;
      step();
      check("t5_first_count", 32'(active_count), 6);
      step();
      hit = 1'b0;
      check("t5_idle_count", 32'(active_count), 6);
      check("t5_idle_y", 32'(b_y), 51);
      check("t5_idle_active", 32'(b_active), 0);

      // 6: asynchronous reset during a tick
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_spawn(i, 20 + i, 2);
         step();
      end
      spawn_valid = 1'b0;
      check("t6_pre_count", 32'(active_count), 4);
      rd_idx_a = 3'd1;
      rd_idx_b = 3'd2;
      tick = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("t6_count", 32'(active_count), 0);
      check("t6_a_y", 32'(a_y), 0);
      check("t6_b_y", 32'(b_y), 0);
      check("t6_a_active", 32'(a_active), 0);
      check("t6_ready", 32'(spawn_ready), 1);
      tick = 1'b0;
      do_reset();
      check("t6_post_count", 32'(active_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
